// File: rtl/rv_mem_wb.sv
// Memory-access / write-back stage of the 5-stage RISC-V pipeline (Q103H -> Q104H).
// Runs data-memory load/store over a req/ack handshake and registers the write-back result.
module rv_mem_wb #(
    parameter int DMEM_AW = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_Q103H,
    input  logic [31:0]        alu_out_Q103H,
    input  logic [31:0]        pc_Q103H,
    input  logic [31:0]        store_data_Q103H,
    input  logic [4:0]         rd_Q103H,
    input  logic               reg_write_Q103H,
    input  logic               mem_rd_Q103H,
    input  logic               mem_wr_Q103H,
    input  logic [1:0]         mem_size_Q103H,
    input  logic               mem_unsigned_Q103H,
    input  logic [1:0]         wb_sel_Q103H,
    output logic               stall_Q103H,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [3:0]         dmem_be,
    output logic [31:0]        dmem_wdata,
    input  logic               dmem_ack,
    input  logic [31:0]        dmem_rdata,
    output logic [31:0]        wb_data_Q104H,
    output logic [4:0]         reg_dst_Q104H,
    output logic               reg_write_en_Q104H,
    output logic               misalign_Q104H
);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

    state_t             r_state;
    logic               r_we;
    logic [DMEM_AW-1:0] r_addr;
    logic [3:0]         r_be;
    logic [31:0]        r_wdata;

    logic               w_mem;
    logic               w_misal;
    logic               w_issue;
    logic               w_complete;
    logic [1:0]         w_off;
    logic [DMEM_AW-1:0] w_addr;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;
    logic [31:0]        w_shift;
    logic [31:0]        w_load;
    logic [31:0]        w_wb;

    // Request formation, misalignment detection and store lane steering
    always_comb begin
        w_mem   = valid_Q103H & (mem_rd_Q103H | mem_wr_Q103H);
        w_off   = alu_out_Q103H[1:0];
        w_addr  = {alu_out_Q103H[DMEM_AW-1:2], 2'b00};
        w_misal = 1'b0;
        w_be    = 4'b1111;
        w_wdata = store_data_Q103H;
        case (mem_size_Q103H)
            2'd0: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{store_data_Q103H[7:0]}};
            end
            2'd1: begin
                w_misal = w_off[0];
                w_be    = 4'b0011 << w_off;
                w_wdata = {2{store_data_Q103H[15:0]}};
            end
            default: begin
                w_misal = (w_off != 2'd0);
                w_be    = 4'b1111;
                w_wdata = store_data_Q103H;
            end
        endcase
        w_issue = (r_state == ST_IDLE) & w_mem & ~w_misal;
        // In IDLE a misaligned or non-memory instruction finishes without waiting for ack
        if (r_state == ST_IDLE) begin
            w_complete = valid_Q103H & (~w_mem | w_misal | dmem_ack);
        end else begin
            w_complete = dmem_ack;
        end
    end

    // Memory port drive: live inputs on the issue cycle, latched copy while waiting
    always_comb begin
        dmem_req    = w_issue | (r_state == ST_WAIT);
        stall_Q103H = dmem_req & ~dmem_ack;
        if (r_state == ST_WAIT) begin
            dmem_we    = r_we;
            dmem_addr  = r_addr;
            dmem_be    = r_be;
            dmem_wdata = r_wdata;
        end else if (w_issue) begin
            dmem_we    = mem_wr_Q103H;
            dmem_addr  = w_addr;
            dmem_be    = w_be;
            dmem_wdata = w_wdata;
        end else begin
            dmem_we    = 1'b0;
            dmem_addr  = {DMEM_AW{1'b0}};
            dmem_be    = 4'b0000;
            dmem_wdata = 32'd0;
        end
    end

    // Load formatting and write-back source selection
    always_comb begin
        w_shift = dmem_rdata >> {w_off, 3'b000};
        case (mem_size_Q103H)
            2'd0: w_load = mem_unsigned_Q103H ? {24'd0, w_shift[7:0]}
                                              : {{24{w_shift[7]}}, w_shift[7:0]};
            2'd1: w_load = mem_unsigned_Q103H ? {16'd0, w_shift[15:0]}
                                              : {{16{w_shift[15]}}, w_shift[15:0]};
            default: w_load = dmem_rdata;
        endcase
        case (wb_sel_Q103H)
            2'd0:    w_wb = alu_out_Q103H;
            2'd1:    w_wb = w_load;
            2'd2:    w_wb = pc_Q103H + 32'd4;
            default: w_wb = 32'd0;
        endcase
    end

    // Handshake FSM, request latch and Q104H write-back registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state            <= ST_IDLE;
            r_we               <= 1'b0;
            r_addr             <= {DMEM_AW{1'b0}};
            r_be               <= 4'b0000;
            r_wdata            <= 32'd0;
            wb_data_Q104H      <= 32'd0;
            reg_dst_Q104H      <= 5'd0;
            reg_write_en_Q104H <= 1'b0;
            misalign_Q104H     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_issue) begin
                        r_we    <= mem_wr_Q103H;
                        r_addr  <= w_addr;
                        r_be    <= w_be;
                        r_wdata <= w_wdata;
                        r_state <= dmem_ack ? ST_IDLE : ST_WAIT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    r_state <= dmem_ack ? ST_IDLE : ST_WAIT;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
            if (w_complete) begin
                wb_data_Q104H      <= w_wb;
                reg_dst_Q104H      <= rd_Q103H;
                reg_write_en_Q104H <= reg_write_Q103H & (rd_Q103H != 5'd0) & ~(w_mem & w_misal);
                misalign_Q104H     <= w_mem & w_misal;
            end else begin
                reg_write_en_Q104H <= 1'b0;
                misalign_Q104H     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rv_mem_wb.sv
// Directed self-checking bench for rv_mem_wb: inputs change 1ns after posedge,
// combinational outputs are checked mid-cycle and Q104H outputs 1ns after the next edge.
module tb_rv_mem_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_Q103H;
    logic [31:0] alu_out_Q103H;
    logic [31:0] pc_Q103H;
    logic [31:0] store_data_Q103H;
    logic [4:0]  rd_Q103H;
    logic        reg_write_Q103H;
    logic        mem_rd_Q103H;
    logic        mem_wr_Q103H;
    logic [1:0]  mem_size_Q103H;
    logic        mem_unsigned_Q103H;
    logic [1:0]  wb_sel_Q103H;
    logic        stall_Q103H;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] wb_data_Q104H;
    logic [4:0]  reg_dst_Q104H;
    logic        reg_write_en_Q104H;
    logic        misalign_Q104H;

    int n_checks = 0;
    int n_errors = 0;

    rv_mem_wb #(.DMEM_AW(32)) dut (
        .clk                (clk),
        .rst                (rst),
        .valid_Q103H        (valid_Q103H),
        .alu_out_Q103H      (alu_out_Q103H),
        .pc_Q103H           (pc_Q103H),
        .store_data_Q103H   (store_data_Q103H),
        .rd_Q103H           (rd_Q103H),
        .reg_write_Q103H    (reg_write_Q103H),
        .mem_rd_Q103H       (mem_rd_Q103H),
        .mem_wr_Q103H       (mem_wr_Q103H),
        .mem_size_Q103H     (mem_size_Q103H),
        .mem_unsigned_Q103H (mem_unsigned_Q103H),
        .wb_sel_Q103H       (wb_sel_Q103H),
        .stall_Q103H        (stall_Q103H),
        .dmem_req           (dmem_req),
        .dmem_we            (dmem_we),
        .dmem_addr          (dmem_addr),
        .dmem_be            (dmem_be),
        .dmem_wdata         (dmem_wdata),
        .dmem_ack           (dmem_ack),
        .dmem_rdata         (dmem_rdata),
        .wb_data_Q104H      (wb_data_Q104H),
        .reg_dst_Q104H      (reg_dst_Q104H),
        .reg_write_en_Q104H (reg_write_en_Q104H),
        .misalign_Q104H     (misalign_Q104H)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        #4;
    endtask

    task automatic idle_inputs();
        valid_Q103H        = 1'b0;
        alu_out_Q103H      = 32'd0;
        pc_Q103H           = 32'd0;
        store_data_Q103H   = 32'd0;
        rd_Q103H           = 5'd0;
        reg_write_Q103H    = 1'b0;
        mem_rd_Q103H       = 1'b0;
        mem_wr_Q103H       = 1'b0;
        mem_size_Q103H     = 2'd0;
        mem_unsigned_Q103H = 1'b0;
        wb_sel_Q103H       = 2'd0;
        dmem_ack           = 1'b0;
        dmem_rdata         = 32'd0;
    endtask

    task automatic load(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                        input logic [4:0] rd, input logic ack, input logic [31:0] rdata);
        idle_inputs();
        valid_Q103H        = 1'b1;
        alu_out_Q103H      = addr;
        mem_rd_Q103H       = 1'b1;
        mem_size_Q103H     = size;
        mem_unsigned_Q103H = uns;
        rd_Q103H           = rd;
        reg_write_Q103H    = 1'b1;
        wb_sel_Q103H       = 2'd1;
        dmem_ack           = ack;
        dmem_rdata         = rdata;
    endtask

    task automatic store(input logic [31:0] addr, input logic [1:0] size,
                         input logic [31:0] sd, input logic ack);
        idle_inputs();
        valid_Q103H      = 1'b1;
        alu_out_Q103H    = addr;
        mem_wr_Q103H     = 1'b1;
        mem_size_Q103H   = size;
        store_data_Q103H = sd;
        rd_Q103H         = 5'd7;
        dmem_ack         = ack;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_wb_data", wb_data_Q104H, 32'd0);
        chk("rst_reg_dst", {27'd0, reg_dst_Q104H}, 32'd0);
        chk("rst_we", {31'd0, reg_write_en_Q104H}, 32'd0);
        chk("rst_misalign", {31'd0, misalign_Q104H}, 32'd0);
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        rst = 1'b0;

        // 1: ADD write-back
        idle_inputs();
        valid_Q103H = 1'b1; alu_out_Q103H = 32'h12345678; rd_Q103H = 5'd5;
        reg_write_Q103H = 1'b1; wb_sel_Q103H = 2'd0;
        mid();
        chk("add_stall", {31'd0, stall_Q103H}, 32'd0);
        chk("add_req", {31'd0, dmem_req}, 32'd0);
        tick();
        chk("add_wb", wb_data_Q104H, 32'h12345678);
        chk("add_dst", {27'd0, reg_dst_Q104H}, 32'd5);
        chk("add_we", {31'd0, reg_write_en_Q104H}, 32'd1);

        // 2: LB zero-wait, signed then unsigned
        load(32'h00001003, 2'd0, 1'b0, 5'd6, 1'b1, 32'h80AA55CC);
        mid();
        chk("lb_req", {31'd0, dmem_req}, 32'd1);
        chk("lb_addr", dmem_addr, 32'h00001000);
        chk("lb_we", {31'd0, dmem_we}, 32'd0);
        chk("lb_stall", {31'd0, stall_Q103H}, 32'd0);
        tick();
        chk("lb_wb", wb_data_Q104H, 32'hFFFFFF80);
        chk("lb_dst", {27'd0, reg_dst_Q104H}, 32'd6);
        load(32'h00001003, 2'd0, 1'b1, 5'd6, 1'b1, 32'h80AA55CC);
        tick();
        chk("lbu_wb", wb_data_Q104H, 32'h00000080);
        chk("lbu_we", {31'd0, reg_write_en_Q104H}, 32'd1);

        // LH signed at offset 2, LW aligned
        load(32'h00004002, 2'd1, 1'b0, 5'd9, 1'b1, 32'h80011234);
        tick();
        chk("lh_wb", wb_data_Q104H, 32'hFFFF8001);
        load(32'h00005000, 2'd2, 1'b1, 5'd10, 1'b1, 32'hCAFEF00D);
        tick();
        chk("lw_wb", wb_data_Q104H, 32'hCAFEF00D);

        // SB zero-wait at offset 1
        store(32'h00006001, 2'd0, 32'h123456AB, 1'b1);
        mid();
        chk("sb_be", {28'd0, dmem_be}, 32'h2);
        chk("sb_wdata", dmem_wdata, 32'hABABABAB);
        chk("sb_we", {31'd0, dmem_we}, 32'd1);
        tick();
        chk("sb_wb_we", {31'd0, reg_write_en_Q104H}, 32'd0);

        // 3: SH with three wait cycles; store_data perturbed to prove the latch holds
        store(32'h00002002, 2'd1, 32'h0000BEEF, 1'b0);
        for (int k = 0; k < 3; k++) begin
            mid();
            chk("sh_stall", {31'd0, stall_Q103H}, 32'd1);
            chk("sh_req", {31'd0, dmem_req}, 32'd1);
            chk("sh_addr", dmem_addr, 32'h00002000);
            chk("sh_be", {28'd0, dmem_be}, 32'hC);
            chk("sh_wdata", dmem_wdata, 32'hBEEFBEEF);
            tick();
            chk("sh_wait_we", {31'd0, reg_write_en_Q104H}, 32'd0);
            store_data_Q103H = 32'h11112222;
        end
        dmem_ack = 1'b1;
        mid();
        chk("sh_ack_stall", {31'd0, stall_Q103H}, 32'd0);
        chk("sh_ack_wdata", dmem_wdata, 32'hBEEFBEEF);
        tick();
        chk("sh_done_we", {31'd0, reg_write_en_Q104H}, 32'd0);
        idle_inputs();
        mid();
        chk("sh_after_req", {31'd0, dmem_req}, 32'd0);
        tick();

        // 4: misaligned LW
        load(32'h00003001, 2'd2, 1'b0, 5'd8, 1'b0, 32'h0);
        mid();
        chk("mis_req", {31'd0, dmem_req}, 32'd0);
        chk("mis_stall", {31'd0, stall_Q103H}, 32'd0);
        tick();
        chk("mis_pulse", {31'd0, misalign_Q104H}, 32'd1);
        chk("mis_we", {31'd0, reg_write_en_Q104H}, 32'd0);
        idle_inputs();
        tick();
        chk("mis_pulse_end", {31'd0, misalign_Q104H}, 32'd0);

        // 5: JAL with PC wrap, then rd=0
        idle_inputs();
        valid_Q103H = 1'b1; pc_Q103H = 32'hFFFFFFFC; rd_Q103H = 5'd1;
        reg_write_Q103H = 1'b1; wb_sel_Q103H = 2'd2;
        tick();
        chk("jal_wb", wb_data_Q104H, 32'h00000000);
        chk("jal_we", {31'd0, reg_write_en_Q104H}, 32'd1);
        chk("jal_dst", {27'd0, reg_dst_Q104H}, 32'd1);
        pc_Q103H = 32'h00000100; rd_Q103H = 5'd0;
        tick();
        chk("jal_x0_wb", wb_data_Q104H, 32'h00000104);
        chk("jal_x0_we", {31'd0, reg_write_en_Q104H}, 32'd0);

        // 6: reset during WAIT of a LW, late ack ignored
        load(32'h00007000, 2'd2, 1'b0, 5'd12, 1'b0, 32'hDEADBEEF);
        mid();
        chk("rw_stall", {31'd0, stall_Q103H}, 32'd1);
        tick();
        chk("rw_hold_wb", wb_data_Q104H, 32'h00000104);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        dmem_ack = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        mid();
        chk("rw_req", {31'd0, dmem_req}, 32'd0);
        chk("rw_wb", wb_data_Q104H, 32'd0);
        chk("rw_dst", {27'd0, reg_dst_Q104H}, 32'd0);
        chk("rw_we", {31'd0, reg_write_en_Q104H}, 32'd0);
        tick();
        chk("rw_late_we", {31'd0, reg_write_en_Q104H}, 32'd0);
        chk("rw_late_wb", wb_data_Q104H, 32'd0);
        chk("rw_late_req", {31'd0, dmem_req}, 32'd0);
        idle_inputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
